// File: rtl/mac_kbd_pkg.sv
// Shared constants and types for the Mac keyboard FIFO front end.
package mac_kbd_pkg;

  typedef enum logic [7:0] {
    CMD_NONE    = 8'h00,
    CMD_INQUIRY = 8'h10,
    CMD_INSTANT = 8'h14,
    CMD_MODEL   = 8'h16,
    CMD_TEST    = 8'h36
  } mac_cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    INQ
  } kbd_state_e;

  localparam logic [7:0] PREFIX_71    = 8'h71;
  localparam logic [7:0] PREFIX_79    = 8'h79;
  localparam logic [9:0] CAPS_PRESS   = 10'h073;
  localparam logic [9:0] CAPS_RELEASE = 10'h0F3;

  function automatic logic is_cmd(input logic [7:0] code);
    logic ok;
    case (code)
      CMD_INQUIRY, CMD_INSTANT, CMD_MODEL, CMD_TEST: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mac_keyboard_fifo_if.sv
// Mac-side command/reply bus: commands flow Mac -> keyboard, replies keyboard -> Mac.
interface mac_keyboard_fifo_if;
  logic [7:0] data_out;
  logic       strobe_out;
  logic [7:0] data_in;
  logic       strobe_in;

  modport master (output data_out, output strobe_out, input data_in, input strobe_in);
  modport slave  (input data_out, input strobe_out, output data_in, output strobe_in);
endinterface

// File: rtl/mac_kbd_fifo.sv
// Synchronous FIFO for key events; push while full is accepted only alongside a pop.
module mac_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mac_keyboard_fifo.sv
// Host key events -> FIFO -> Mac keyboard-protocol replies, paced by an en-cycle counter.
// state | meaning: IDLE no command pending | WAIT pacing to SHORT_TICKS | INQ inquiry waiting for a key or timeout
module mac_keyboard_fifo
  import mac_kbd_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         SHORT_TICKS = 4095,
  parameter int         LONG_TICKS  = 1048575,
  parameter logic [7:0] MODEL_ID    = 8'h0B,
  parameter logic [7:0] TEST_ACK    = 8'h7D,
  parameter logic [7:0] NULL_CODE   = 8'h7B
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         kbd_strobe,
  input  logic [9:0]                   kbd_data,
  mac_keyboard_fifo_if.slave           mac,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  output logic                         caps_state
);

  localparam int             CW      = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0]  SHORT_C = CW'(SHORT_TICKS);
  localparam logic [CW-1:0]  LONG_C  = CW'(LONG_TICKS);

  kbd_state_e     state, state_nxt;
  mac_cmd_e       cmd_q;
  logic [CW-1:0]  cnt;
  logic [1:0]     sub_idx, sub_nxt;
  logic           strobe_q;

  logic           key_ev, push_req;
  logic [9:0]     push_data;
  logic [9:0]     head;
  logic           fifo_full, fifo_empty, fifo_pop;

  logic           reply_fire, send_key, do_flush;
  logic [7:0]     fixed_byte, key_byte, reply_byte;
  logic           key_last;

  // Ingress: a toggle on kbd_strobe marks one event; caps release is swallowed.
  assign key_ev    = en && (kbd_strobe != strobe_q);
  assign push_req  = key_ev && (kbd_data != CAPS_RELEASE);
  assign push_data = (kbd_data == CAPS_PRESS) ? {kbd_data[9:8], caps_state, CAPS_PRESS[6:0]}
                                              : kbd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q   <= 1'b0;
      caps_state <= 1'b0;
    end else if (en) begin
      strobe_q <= kbd_strobe;
      if (key_ev && kbd_data == CAPS_PRESS) caps_state <= ~caps_state;
    end
  end

  mac_kbd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .pop       (fifo_pop),
    .flush     (do_flush),
    .push_data (push_data),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (do_flush) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      cmd_q <= CMD_NONE;
    end else if (en) begin
      if (mac.strobe_out) begin
        cnt   <= '0;
        cmd_q <= is_cmd(mac.data_out) ? mac_cmd_e'(mac.data_out) : CMD_NONE;
      end else if (cnt != LONG_C) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Head-entry byte sequencer: sub_idx[0] = 0x71 prefix sent, sub_idx[1] = 0x79 prefix sent.
  always_comb begin
    key_byte = head[7:0];
    key_last = 1'b1;
    sub_nxt  = 2'b00;
    if (head[9] && !sub_idx[0]) begin
      key_byte = {head[7], PREFIX_71[6:0]};
      key_last = 1'b0;
      sub_nxt  = sub_idx | 2'b01;
    end else if (head[8] && !sub_idx[1]) begin
      key_byte = PREFIX_79;
      key_last = 1'b0;
      sub_nxt  = sub_idx | 2'b10;
    end
  end

  assign fifo_pop = send_key && key_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_idx <= 2'b00;
    end else if (do_flush) begin
      sub_idx <= 2'b00;
    end else if (send_key) begin
      sub_idx <= sub_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      if (mac.strobe_out) begin
        state_nxt = is_cmd(mac.data_out) ? WAIT : IDLE;
      end else begin
        case (state)
          WAIT: if (cnt == SHORT_C) begin
            state_nxt = (cmd_q == CMD_INQUIRY && fifo_empty) ? INQ : IDLE;
          end
          INQ:  if (!fifo_empty || cnt == LONG_C) state_nxt = IDLE;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // A command arriving in the same cycle as a due reply takes priority and abandons it.
  always_comb begin
    reply_fire = 1'b0;
    send_key   = 1'b0;
    do_flush   = 1'b0;
    fixed_byte = NULL_CODE;
    if (en && !mac.strobe_out) begin
      case (state)
        WAIT: if (cnt == SHORT_C) begin
          case (cmd_q)
            CMD_MODEL: begin
              reply_fire = 1'b1;
              fixed_byte = MODEL_ID;
              do_flush   = 1'b1;
            end
            CMD_TEST: begin
              reply_fire = 1'b1;
              fixed_byte = TEST_ACK;
              do_flush   = 1'b1;
            end
            CMD_INSTANT: begin
              reply_fire = 1'b1;
              send_key   = !fifo_empty;
            end
            CMD_INQUIRY: if (!fifo_empty) begin
              reply_fire = 1'b1;
              send_key   = 1'b1;
            end
            default: reply_fire = 1'b0;
          endcase
        end
        INQ: begin
          if (!fifo_empty) begin
            reply_fire = 1'b1;
            send_key   = 1'b1;
          end else if (cnt == LONG_C) begin
            reply_fire = 1'b1;
          end
        end
        default: reply_fire = 1'b0;
      endcase
    end
  end

  assign reply_byte    = send_key ? key_byte : fixed_byte;
  assign mac.strobe_in = reply_fire;
  assign mac.data_in   = reply_fire ? reply_byte : NULL_CODE;

endmodule

// File: tb/tb_mac_keyboard_fifo.sv
// Directed bench for mac_keyboard_fifo with shortened pacing so long timeouts stay cheap.
module tb_mac_keyboard_fifo;
  import mac_kbd_pkg::*;

  localparam int DEPTH = 8;
  localparam int SHORT = 15;
  localparam int LONG  = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       kbd_strobe;
  logic [9:0] kbd_data;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       caps_state;

  mac_keyboard_fifo_if mac_bus ();

  mac_keyboard_fifo #(
    .FIFO_DEPTH  (DEPTH),
    .SHORT_TICKS (SHORT),
    .LONG_TICKS  (LONG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .kbd_strobe (kbd_strobe),
    .kbd_data   (kbd_data),
    .mac        (mac_bus),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .caps_state (caps_state)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         lat;
  logic [7:0] rb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_key(input logic [9:0] d);
    @(posedge clk);
    #1 kbd_data = d;
    kbd_strobe = ~kbd_strobe;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(posedge clk);
    #1 mac_bus.data_out = c;
    mac_bus.strobe_out = 1'b1;
    @(posedge clk);
    #1 mac_bus.strobe_out = 1'b0;
    mac_bus.data_out = 8'h00;
  endtask

  // lat counts clock cycles after the command cycle up to the reply cycle.
  task automatic cmd_wait(input logic [7:0] c, input int stall, input int budget,
                          output int l, output logic [7:0] b);
    send_cmd(c);
    l = 1;
    b = 'x;
    if (stall > 0) begin
      en = 1'b0;
      repeat (stall) @(posedge clk);
      #1 en = 1'b1;
      l += stall;
    end
    #1;
    while (l <= budget && !mac_bus.strobe_in) begin
      @(posedge clk);
      #2;
      l++;
    end
    if (mac_bus.strobe_in) b = mac_bus.data_in;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    en                 = 1'b1;
    kbd_strobe         = 1'b0;
    kbd_data           = 10'h000;
    mac_bus.data_out   = 8'h00;
    mac_bus.strobe_out = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_data_in",   32'(mac_bus.data_in),   32'h7B);
    chk("rst_strobe_in", 32'(mac_bus.strobe_in), 32'h0);
    chk("rst_level",     32'(fifo_level),        32'h0);
    chk("rst_overflow",  32'(overflow),          32'h0);
    chk("rst_caps",      32'(caps_state),        32'h0);

    // MODEL reply after SHORT+1 cycles, one-cycle pulse
    cmd_wait(8'h16, 0, 40, lat, rb);
    chk("model_lat",  32'(lat), 32'(SHORT + 1));
    chk("model_byte", 32'(rb),  32'h0B);
    tick(1);
    chk("model_pulse_end", 32'(mac_bus.strobe_in), 32'h0);
    chk("model_idle_data", 32'(mac_bus.data_in),   32'h7B);
    chk("model_level",     32'(fifo_level),        32'h0);

    // en low stalls the pace counter
    cmd_wait(8'h16, 7, 60, lat, rb);
    chk("stall_lat",  32'(lat), 32'(SHORT + 1 + 7));
    chk("stall_byte", 32'(rb),  32'h0B);

    // MODEL abandoned by a new INSTANT command
    send_cmd(8'h16);
    tick(5);
    chk("abandon_quiet", 32'(mac_bus.strobe_in), 32'h0);
    cmd_wait(8'h14, 0, 40, lat, rb);
    chk("abandon_lat",  32'(lat), 32'(SHORT + 1));
    chk("abandon_byte", 32'(rb),  32'h7B);

    // unknown code cancels a pending MODEL and never replies
    send_cmd(8'h16);
    tick(3);
    cmd_wait(8'h55, 0, 40, lat, rb);
    chk("unknown_no_reply", 32'(lat), 32'd41);

    // INQUIRY with a queued key replies at the short tick
    push_key(10'h012);
    tick(1);
    chk("inq_level_before", 32'(fifo_level), 32'h1);
    cmd_wait(8'h10, 0, 40, lat, rb);
    chk("inq_lat",  32'(lat), 32'(SHORT + 1));
    chk("inq_byte", 32'(rb),  32'h12);
    tick(1);
    chk("inq_level_after", 32'(fifo_level), 32'h0);

    // keypad event with both prefixes: three bytes, removed after the last
    push_key(10'h3C4);
    tick(1);
    cmd_wait(8'h14, 0, 40, lat, rb);
    chk("kp_byte0", 32'(rb), 32'hF1);
    tick(1);
    chk("kp_level0", 32'(fifo_level), 32'h1);
    cmd_wait(8'h14, 0, 40, lat, rb);
    chk("kp_byte1", 32'(rb), 32'h79);
    tick(1);
    chk("kp_level1", 32'(fifo_level), 32'h1);
    cmd_wait(8'h14, 0, 40, lat, rb);
    chk("kp_byte2", 32'(rb), 32'hC4);
    tick(1);
    chk("kp_level2", 32'(fifo_level), 32'h0);

    // INQUIRY timeout on an empty FIFO, then a late key stays queued
    cmd_wait(8'h10, 0, 100, lat, rb);
    chk("inq_to_lat",  32'(lat), 32'(LONG + 1));
    chk("inq_to_byte", 32'(rb),  32'h7B);
    push_key(10'h055);
    tick(4);
    chk("late_key_level", 32'(fifo_level), 32'h1);

    // overflow: nine events into depth eight
    for (int i = 0; i < 8; i++) push_key(10'(10'h060 + i));
    tick(1);
    chk("ovf_level", 32'(fifo_level), 32'h8);
    chk("ovf_flag",  32'(overflow),   32'h1);
    cmd_wait(8'h36, 0, 40, lat, rb);
    chk("test_byte", 32'(rb), 32'h7D);
    tick(1);
    chk("test_level",    32'(fifo_level), 32'h0);
    chk("test_overflow", 32'(overflow),   32'h0);

    // caps press / release / press
    push_key(10'h073);
    tick(1);
    chk("caps_after_press1", 32'(caps_state), 32'h1);
    push_key(10'h0F3);
    tick(1);
    chk("caps_release_level", 32'(fifo_level), 32'h1);
    chk("caps_after_release", 32'(caps_state), 32'h1);
    push_key(10'h073);
    tick(1);
    chk("caps_after_press2", 32'(caps_state), 32'h0);
    chk("caps_level",        32'(fifo_level), 32'h2);
    cmd_wait(8'h14, 0, 40, lat, rb);
    chk("caps_byte0", 32'(rb), 32'h73);
    cmd_wait(8'h14, 0, 40, lat, rb);
    chk("caps_byte1", 32'(rb), 32'hF3);
    tick(1);
    chk("caps_level_end", 32'(fifo_level), 32'h0);

    // full FIFO: push coinciding with a final-byte pop is accepted
    for (int i = 1; i <= 8; i++) push_key(10'(i));
    tick(1);
    chk("full_level", 32'(fifo_level), 32'h8);
    send_cmd(8'h14);
    repeat (SHORT) @(posedge clk);
    #1 kbd_data = 10'h0AA;
    kbd_strobe = ~kbd_strobe;
    #1;
    chk("full_pop_strobe", 32'(mac_bus.strobe_in), 32'h1);
    chk("full_pop_byte",   32'(mac_bus.data_in),   32'h01);
    tick(1);
    chk("full_pop_level",    32'(fifo_level), 32'h8);
    chk("full_pop_overflow", 32'(overflow),   32'h0);
    cmd_wait(8'h14, 0, 40, lat, rb);
    chk("full_next_byte", 32'(rb), 32'h02);
    push_key(10'h0BB);
    push_key(10'h0BC);
    tick(1);
    chk("full_drop_overflow", 32'(overflow),   32'h1);
    chk("full_drop_level",    32'(fifo_level), 32'h8);
    chk("caps_kept",          32'(caps_state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
